// File: rtl/bp_axil_nbf_pkg.sv
// Shared types and constants for the AXI-Lite NBF sink: command layout, flit count, register map.
package bp_axil_nbf_pkg;

  localparam int unsigned nbf_flits_lp = 5;

  localparam logic [63:0] resp_cnt_addr_lp  = 64'h10;
  localparam logic [63:0] resp_data_addr_lp = 64'h14;
  localparam logic [63:0] stats_addr_lp     = 64'h18;

  localparam logic [1:0] axil_resp_okay_lp   = 2'b00;
  localparam logic [1:0] axil_resp_slverr_lp = 2'b10;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [63:0] addr;
    logic [63:0] data;
  } bp_nbf_s;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear wins over up.
module bsg_counter_clear_up #(
  parameter int unsigned max_val_p = 4,
  parameter int unsigned width_p   = $clog2(max_val_p + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (up_i) begin
      count_o <= count_o + width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO with occupancy count; yumi_i pops only when v_o is high.
module bsg_fifo_1r1w_small #(
  parameter int unsigned width_p       = 32,
  parameter int unsigned els_p         = 16,
  parameter int unsigned count_width_p = $clog2(els_p + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [width_p-1:0]       data_i,
  input  logic                     v_i,
  output logic                     ready_o,
  output logic [width_p-1:0]       data_o,
  output logic                     v_o,
  input  logic                     yumi_i,
  output logic [count_width_p-1:0] count_o
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, rd_ptr_q;
  logic                push_c, pop_c;

  assign ready_o = (count_o != count_width_p'(els_p));
  assign v_o     = (count_o != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign push_c  = v_i & ready_o;
  assign pop_c   = yumi_i & v_o;

  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_o  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= (wr_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_q + ptr_w_lp'(1);
      if (pop_c)  rd_ptr_q <= (rd_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_q + ptr_w_lp'(1);
      case ({push_c, pop_c})
        2'b10:   count_o <= count_o + count_width_p'(1);
        2'b01:   count_o <= count_o - count_width_p'(1);
        default: count_o <= count_o;
      endcase
    end
  end

endmodule

// File: rtl/bp_axil_nbf_sink.sv
// AXI-Lite sink reassembling 32b flits into NBF commands, plus a polled response FIFO.
// Optional BP_AXIL_NBF_SINK_STATS_EN maps a delivered-command counter at 0x18.
module bp_axil_nbf_sink
  import bp_axil_nbf_pkg::*;
#(
  parameter int unsigned S_AXIL_ADDR_WIDTH = 64,
  parameter int unsigned S_AXIL_DATA_WIDTH = 32,
  parameter logic [63:0] nbf_host_addr_p   = 64'h0,
  parameter int unsigned resp_fifo_els_p   = 16
) (
  input  logic                         s_axil_aclk,
  input  logic                         s_axil_aresetn,
  input  logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [2:0]                   s_axil_awprot,
  input  logic [S_AXIL_DATA_WIDTH-1:0] s_axil_wdata,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  input  logic [3:0]                   s_axil_wstrb,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  output logic [1:0]                   s_axil_bresp,
  input  logic [S_AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  input  logic [2:0]                   s_axil_arprot,
  output logic [S_AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  output logic [1:0]                   s_axil_rresp,
  output logic [135:0]                 nbf_o,
  output logic                         nbf_v_o,
  input  logic                         nbf_ready_i,
  input  logic [31:0]                  resp_data_i,
  input  logic                         resp_v_i,
  output logic                         resp_ready_o
);

  localparam int unsigned cnt_w_lp      = $clog2(nbf_flits_lp);
  localparam int unsigned fifo_cnt_w_lp = $clog2(resp_fifo_els_p + 1);

  logic                         ready_en_q;
  logic                         aw_held_q, w_held_q, commit_q, commit_ok_q, last_q;
  logic [S_AXIL_ADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]                  w_data_q;
  logic [3:0]                   w_strb_q;
  logic [31:0]                  flit_q [4];
  logic [7:0]                   opcode_q;
  logic [cnt_w_lp-1:0]          flit_cnt;
  logic                         commit_c, ok_c, flit_up_c, flit_last_c, aw_fire_c, w_fire_c, ar_fire_c;
  logic [31:0]                  rd_data_c;
  logic [1:0]                   rd_resp_c;
  logic                         fifo_ready, fifo_v, fifo_yumi_c;
  logic [31:0]                  fifo_data;
  logic [fifo_cnt_w_lp-1:0]     fifo_count;
  bp_nbf_s                      nbf_s;
  logic                         unused_prot;

  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  // Readies stay low through reset and the first cycle after it.
  assign s_axil_awready = ready_en_q & ~aw_held_q & ~commit_q & ~s_axil_bvalid & ~nbf_v_o;
  assign s_axil_wready  = ready_en_q & ~w_held_q  & ~commit_q & ~s_axil_bvalid & ~nbf_v_o;
  assign s_axil_arready = ready_en_q & ~s_axil_rvalid;
  assign resp_ready_o   = ready_en_q & fifo_ready;

  assign aw_fire_c   = s_axil_awvalid & s_axil_awready;
  assign w_fire_c    = s_axil_wvalid & s_axil_wready;
  assign ar_fire_c   = s_axil_arvalid & s_axil_arready;
  assign commit_c    = aw_held_q & w_held_q;
  assign ok_c        = (aw_addr_q == S_AXIL_ADDR_WIDTH'(nbf_host_addr_p)) & (w_strb_q == 4'hF);
  assign flit_up_c   = commit_c & ok_c;
  assign flit_last_c = (flit_cnt == cnt_w_lp'(nbf_flits_lp - 1));

  bsg_counter_clear_up #(.max_val_p(nbf_flits_lp - 1), .width_p(cnt_w_lp)) flit_counter (
    .clk     (s_axil_aclk),
    .rst_n   (s_axil_aresetn),
    .clear_i (flit_up_c & flit_last_c),
    .up_i    (flit_up_c),
    .count_o (flit_cnt)
  );

  bsg_fifo_1r1w_small #(.width_p(32), .els_p(resp_fifo_els_p), .count_width_p(fifo_cnt_w_lp)) resp_fifo (
    .clk     (s_axil_aclk),
    .rst_n   (s_axil_aresetn),
    .data_i  (resp_data_i),
    .v_i     (resp_v_i & ready_en_q),
    .ready_o (fifo_ready),
    .data_o  (fifo_data),
    .v_o     (fifo_v),
    .yumi_i  (fifo_yumi_c),
    .count_o (fifo_count)
  );

  always_comb begin
    nbf_s.opcode = opcode_q;
    nbf_s.addr   = {flit_q[3], flit_q[2]};
    nbf_s.data   = {flit_q[1], flit_q[0]};
  end
  assign nbf_o = nbf_s;

`ifdef BP_AXIL_NBF_SINK_STATS_EN
  logic [31:0] stats_q;

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      stats_q <= '0;
    end else if (nbf_v_o & nbf_ready_i & (stats_q != '1)) begin
      stats_q <= stats_q + 32'd1;
    end
  end
`endif

  // Read decode; an empty data read returns zero without popping.
  always_comb begin
    rd_data_c   = '0;
    rd_resp_c   = axil_resp_slverr_lp;
    fifo_yumi_c = 1'b0;
    if (s_axil_araddr == S_AXIL_ADDR_WIDTH'(resp_cnt_addr_lp)) begin
      rd_data_c = 32'(fifo_count);
      rd_resp_c = axil_resp_okay_lp;
    end else if (s_axil_araddr == S_AXIL_ADDR_WIDTH'(resp_data_addr_lp)) begin
      rd_resp_c = axil_resp_okay_lp;
      if (fifo_v) begin
        rd_data_c   = fifo_data;
        fifo_yumi_c = ar_fire_c;
      end
    end
`ifdef BP_AXIL_NBF_SINK_STATS_EN
    else if (s_axil_araddr == S_AXIL_ADDR_WIDTH'(stats_addr_lp)) begin
      rd_data_c = stats_q;
      rd_resp_c = axil_resp_okay_lp;
    end
`endif
  end

  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      ready_en_q    <= 1'b0;
      aw_held_q     <= 1'b0;
      w_held_q      <= 1'b0;
      commit_q      <= 1'b0;
      commit_ok_q   <= 1'b0;
      last_q        <= 1'b0;
      aw_addr_q     <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      flit_q        <= '{default: '0};
      opcode_q      <= '0;
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= '0;
      nbf_v_o       <= 1'b0;
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= '0;
    end else begin
      ready_en_q <= 1'b1;
      commit_q   <= commit_c;
      if (aw_fire_c) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= s_axil_awaddr;
      end
      if (w_fire_c) begin
        w_held_q <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end
      if (commit_c) begin
        aw_held_q   <= 1'b0;
        w_held_q    <= 1'b0;
        commit_ok_q <= ok_c;
        last_q      <= ok_c & flit_last_c;
      end
      // Flit slot follows the running count; the fifth flit carries the opcode byte.
      if (flit_up_c) begin
        if (flit_last_c) opcode_q <= w_data_q[7:0];
        else             flit_q[flit_cnt[1:0]] <= w_data_q;
      end
      if (nbf_v_o & nbf_ready_i) nbf_v_o <= 1'b0;
      if (commit_q) begin
        s_axil_bvalid <= 1'b1;
        s_axil_bresp  <= commit_ok_q ? axil_resp_okay_lp : axil_resp_slverr_lp;
        if (last_q) nbf_v_o <= 1'b1;
      end else if (s_axil_bvalid & s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
      if (ar_fire_c) begin
        s_axil_rvalid <= 1'b1;
        s_axil_rdata  <= rd_data_c;
        s_axil_rresp  <= rd_resp_c;
      end else if (s_axil_rvalid & s_axil_rready) begin
        s_axil_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bp_axil_nbf_sink.sv
// Directed bench for bp_axil_nbf_sink: flit assembly, backpressure, write timing, errors, FIFO, reset.
module tb_bp_axil_nbf_sink;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [63:0]  awaddr, araddr;
  logic         awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [2:0]   awprot, arprot;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [135:0] nbf;
  logic         nbf_v, nbf_ready;
  logic [31:0]  resp_data;
  logic         resp_v, resp_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_axil_nbf_sink dut (
    .s_axil_aclk(clk), .s_axil_aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awprot(awprot),
    .s_axil_wdata(wdata), .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wstrb(wstrb),
    .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_arprot(arprot),
    .s_axil_rdata(rdata), .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rresp(rresp),
    .nbf_o(nbf), .nbf_v_o(nbf_v), .nbf_ready_i(nbf_ready),
    .resp_data_i(resp_data), .resp_v_i(resp_v), .resp_ready_o(resp_ready)
  );

  function automatic logic [31:0] flit_of(input logic [135:0] cmd, input int i);
    case (i)
      0:       return cmd[31:0];
      1:       return cmd[63:32];
      2:       return cmd[95:64];
      3:       return cmd[127:96];
      default: return {24'h0, cmd[135:128]};
    endcase
  endfunction

  task automatic axil_write(input logic [63:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic nbf_at_b);
    bit got, fire_aw, fire_w;
    int n;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    got = 0; n = 0; resp = 2'b11; nbf_at_b = 1'b0;
    while (!got && n < 50) begin
      if (bvalid) begin resp = bresp; nbf_at_b = nbf_v; got = 1; end
      fire_aw = awvalid & awready;
      fire_w  = wvalid & wready;
      @(posedge clk); #1;
      if (fire_aw) awvalid = 1'b0;
      if (fire_w)  wvalid  = 1'b0;
      @(negedge clk); n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL write_timeout addr=%h got no bvalid within 50 cycles", addr); end
  endtask

  task automatic axil_read(input logic [63:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit got, fire;
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    got = 0; n = 0; data = 32'hFFFF_FFFF; resp = 2'b11;
    while (!got && n < 50) begin
      if (rvalid) begin data = rdata; resp = rresp; got = 1; end
      fire = arvalid & arready;
      @(posedge clk); #1;
      if (fire) arvalid = 1'b0;
      @(negedge clk); n++;
    end
    arvalid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL read_timeout addr=%h got no rvalid within 50 cycles", addr); end
  endtask

  task automatic send_cmd(input logic [135:0] cmd, output logic all_ok, output logic [4:0] nbf_seen);
    logic [1:0] r;
    logic       nb;
    all_ok = 1'b1; nbf_seen = '0;
    for (int i = 0; i < 5; i++) begin
      axil_write(64'h0, flit_of(cmd, i), 4'hF, r, nb);
      if (r != 2'b00) all_ok = 1'b0;
      nbf_seen[i] = nb;
    end
  endtask

  task automatic release_nbf();
    @(negedge clk); nbf_ready = 1'b1;
    @(negedge clk); nbf_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, nbf_v, resp_ready} !== 7'b0 || bresp !== 2'b0 ||
        rresp !== 2'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL reset_outputs readies/valids=%b bresp=%b rresp=%b rdata=%h required all 0",
                         {awready, wready, arready, bvalid, rvalid, nbf_v, resp_ready}, bresp, rresp, rdata);
    end
    @(negedge clk); aresetn = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({awready, wready, arready, resp_ready} !== 4'b1111) begin
      errors++; $display("FAIL ready_after_reset got=%b required=1111", {awready, wready, arready, resp_ready});
    end
  endtask

  task automatic test_cmd_assembly();
    logic [135:0] c = {8'h02, 64'h0000_0000_8000_0000, 64'hDEAD_BEEF_0123_4567};
    logic         ok;
    logic [4:0]   seen;
    send_cmd(c, ok, seen);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL cmd1_bresp got=%b required=1 (all OKAY)", ok); end
    checks++;
    if (seen !== 5'b10000) begin errors++; $display("FAIL cmd1_nbf_v_at_bvalid got=%b required=10000", seen); end
    checks++;
    if (nbf !== c || nbf_v !== 1'b1) begin
      errors++; $display("FAIL cmd1_nbf_o got=%h v=%b required=%h v=1", nbf, nbf_v, c);
    end
    release_nbf();
    checks++;
    if (nbf_v !== 1'b0) begin errors++; $display("FAIL cmd1_nbf_v_drop got=%b required=0", nbf_v); end
  endtask

  task automatic test_backpressure();
    logic [135:0] c2 = {8'h03, 64'h0000_0001_0000_1234, 64'h0011_2233_4455_6677};
    logic [135:0] c3 = {8'h01, 64'hFFFF_0000_ABCD_0000, 64'h8877_6655_4433_2211};
    logic         ok, nb, blocked;
    logic [4:0]   seen;
    logic [1:0]   r;
    send_cmd(c2, ok, seen);
    checks++;
    if (nbf !== c2 || nbf_v !== 1'b1) begin errors++; $display("FAIL cmd2_nbf_o got=%h required=%h", nbf, c2); end
    @(negedge clk);
    awaddr = 64'h0; awvalid = 1'b1; wdata = flit_of(c3, 0); wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    blocked = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (awready !== 1'b0 || wready !== 1'b0) blocked = 1'b0;
    end
    checks++;
    if (blocked !== 1'b1) begin errors++; $display("FAIL stall_while_nbf_v got ready seen=%b required no ready", ~blocked); end
    awvalid = 1'b0; wvalid = 1'b0;
    release_nbf();
    axil_write(64'h0, flit_of(c3, 0), 4'hF, r, nb);
    checks++;
    if (r !== 2'b00 || nb !== 1'b0) begin errors++; $display("FAIL sixth_flit_accept resp=%b nbf_v=%b required 00/0", r, nb); end
    for (int i = 1; i < 5; i++) axil_write(64'h0, flit_of(c3, i), 4'hF, r, nb);
    checks++;
    if (nbf !== c3 || nbf_v !== 1'b1) begin errors++; $display("FAIL cmd3_nbf_o got=%h required=%h", nbf, c3); end
    release_nbf();
  endtask

  task automatic test_write_timing();
    int n;
    logic held;
    @(negedge clk);
    bready = 1'b0; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1; n = 0;
    while (!wready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1; wvalid = 1'b0;
    repeat (3) @(negedge clk);
    awaddr = 64'h40; awvalid = 1'b1; n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (awready !== 1'b1) begin errors++; $display("FAIL aw_timeout awready=%b required=1", awready); end
    @(posedge clk); #1; awvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_early got=%b required=0 one cycle after AW", bvalid); end
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL bvalid_latency got=%b required=1 two cycles after AW", bvalid); end
    held = 1'b1;
    repeat (4) begin @(negedge clk); if (bvalid !== 1'b1) held = 1'b0; end
    checks++;
    if (held !== 1'b1 || bresp !== 2'b10) begin
      errors++; $display("FAIL bvalid_hold held=%b bresp=%b required held=1 bresp=10", held, bresp);
    end
    bready = 1'b1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_release got=%b required=0", bvalid); end
  endtask

  task automatic test_slverr();
    logic [135:0] c = {8'h07, 64'h0000_0000_0000_2000, 64'hA5A5_5A5A_F0F0_0F0F};
    logic [1:0]   r;
    logic         nb, ok;
    logic [4:0]   seen;
    axil_write(64'h40, 32'h1111_1111, 4'hF, r, nb);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL bad_addr_bresp got=%b required=10", r); end
    axil_write(64'h0, 32'h2222_2222, 4'h3, r, nb);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL bad_strb_bresp got=%b required=10", r); end
    send_cmd(c, ok, seen);
    checks++;
    if (ok !== 1'b1 || seen !== 5'b10000 || nbf !== c) begin
      errors++; $display("FAIL cmd_after_err ok=%b seen=%b nbf=%h required 1/10000/%h", ok, seen, nbf, c);
    end
    release_nbf();
  endtask

  task automatic test_resp_fifo();
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] exp_d [4] = '{32'h11, 32'h22, 32'h33, 32'h0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      resp_data = exp_d[i]; resp_v = 1'b1;
    end
    @(negedge clk); resp_v = 1'b0;
    axil_read(64'h10, d, r);
    checks++;
    if (d !== 32'd3 || r !== 2'b00) begin errors++; $display("FAIL fifo_count3 got=%0d/%b required=3/00", d, r); end
    for (int i = 0; i < 4; i++) begin
      axil_read(64'h14, d, r);
      checks++;
      if (d !== exp_d[i] || r !== 2'b00) begin
        errors++; $display("FAIL fifo_pop%0d got=%h/%b required=%h/00", i, d, r, exp_d[i]);
      end
    end
    axil_read(64'h10, d, r);
    checks++;
    if (d !== 32'd0 || r !== 2'b00) begin errors++; $display("FAIL fifo_count0 got=%0d/%b required=0/00", d, r); end
    axil_read(64'h30, d, r);
    checks++;
    if (d !== 32'd0 || r !== 2'b10) begin errors++; $display("FAIL unmapped_read got=%h/%b required=0/10", d, r); end
  endtask

  task automatic test_mid_cmd_reset();
    logic [135:0] cd = {8'h04, 64'h0000_0000_0000_0BAD, 64'h0BAD_0BAD_0BAD_0BAD};
    logic [135:0] ce = {8'h05, 64'h0000_0000_4000_0040, 64'h1357_9BDF_2468_ACE0};
    logic [1:0]   r;
    logic         nb, ok;
    logic [4:0]   seen;
    logic [31:0]  d;
    @(negedge clk); resp_data = 32'h55; resp_v = 1'b1;
    @(negedge clk); resp_v = 1'b0;
    for (int i = 0; i < 2; i++) axil_write(64'h0, flit_of(cd, i), 4'hF, r, nb);
    @(negedge clk);
    awaddr = 64'h0; awvalid = 1'b1; wdata = flit_of(cd, 2); wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    araddr = 64'h10; arvalid = 1'b1; rready = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valids bvalid=%b rvalid=%b required 1/1", bvalid, rvalid);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, nbf_v, resp_ready} !== 7'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL async_reset readies/valids=%b rdata=%h required all 0",
                         {awready, wready, arready, bvalid, rvalid, nbf_v, resp_ready}, rdata);
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    axil_read(64'h10, d, r);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL fifo_after_reset got=%0d required=0", d); end
    send_cmd(ce, ok, seen);
    checks++;
    if (ok !== 1'b1 || seen !== 5'b10000 || nbf !== ce) begin
      errors++; $display("FAIL clean_cmd_after_reset ok=%b seen=%b nbf=%h required 1/10000/%h", ok, seen, nbf, ce);
    end
    release_nbf();
    axil_read(64'h18, d, r);
    checks++;
`ifdef BP_AXIL_NBF_SINK_STATS_EN
    if (d !== 32'd1 || r !== 2'b00) begin errors++; $display("FAIL stats_read got=%0d/%b required=1/00", d, r); end
`else
    if (d !== 32'd0 || r !== 2'b10) begin errors++; $display("FAIL stats_unmapped got=%0d/%b required=0/10", d, r); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0;
    awaddr = '0; awvalid = 1'b0; awprot = '0; wdata = '0; wvalid = 1'b0; wstrb = '0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; arprot = '0; rready = 1'b0;
    nbf_ready = 1'b0; resp_data = '0; resp_v = 1'b0;
    test_reset();
    test_cmd_assembly();
    test_backpressure();
    test_write_timing();
    test_slverr();
    test_resp_fifo();
    test_mid_cmd_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
